// File: rtl/vga_timing_scaler.sv
// vga_timing_scaler
//   Programmable VGA timing generator with 1x/2x/4x horizontal pixel
//   replication. It issues source-pixel requests with source coordinates,
//   absorbs PIX_LATENCY cycles of fetch latency, and drives latency-aligned
//   registered sync, display-enable and RGB outputs.
//
// Ports
//   clk            pixel clock
//   rst_n          asynchronous active-low reset
//   i_scale_sel    00 = 1x, 01 = 2x, 1x = 4x; takes effect at frame start
//   i_rgb_in       RRRGGGBB source pixel, valid PIX_LATENCY cycles after request
//   i_rgb_valid    qualifies i_rgb_in at its sample point
//   o_pixel_req    combinational request for the next source pixel
//   o_src_x        source column (h_cnt >> scale shift)
//   o_src_y        source row (v_cnt)
//   o_hsync        registered hsync, active level = HSYNC_POL
//   o_vsync        registered vsync, active level = VSYNC_POL
//   o_de           registered display enable
//   o_red/green/blue registered colour outputs
//   o_frame_start  one-cycle pulse coincident with output pixel (0,0)
//   o_underflow    sticky flag, set by a missing pixel, cleared at frame start

module vga_timing_scaler #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          HSYNC_POL   = 1'b0,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned PIX_LATENCY = 1,
    parameter int unsigned CNT_W       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       i_scale_sel,
    input  logic [7:0]       i_rgb_in,
    input  logic             i_rgb_valid,
    output logic             o_pixel_req,
    output logic [CNT_W-1:0] o_src_x,
    output logic [CNT_W-1:0] o_src_y,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [2:0]       o_red,
    output logic [2:0]       o_green,
    output logic [1:0]       o_blue,
    output logic             o_frame_start,
    output logic             o_underflow
);

    localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned SW           = 5;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_START = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_START = CNT_W'(V_DISPLAY);

    // One pipeline slot of per-position control information.
    typedef struct packed {
        logic first;
        logic req;
        logic vs;
        logic hs;
        logic active;
    } stage_t;

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic [1:0]       r_scale;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_h_wrap;
    logic             w_frame_wrap;
    logic [1:0]       w_scale_dec;
    logic [1:0]       w_low_mask;
    logic [31:0]      w_h32;
    logic [31:0]      w_v32;
    stage_t           w_stage0;
    stage_t           w_tail;
    logic [7:0]       w_pix_next;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [7:0]       r_rgb;
    logic [7:0]       r_hold;
    logic             r_frame_start;
    logic             r_underflow;

    // Counter next-state and scale decode.
    always_comb begin
        w_h_wrap     = (r_h_cnt == H_LAST);
        w_frame_wrap = w_h_wrap && (r_v_cnt == V_LAST);
        w_h_next     = w_h_wrap ? '0 : r_h_cnt + CNT_W'(1);
        w_v_next     = r_v_cnt;
        if (w_h_wrap) begin
            w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
        end
        if (i_scale_sel[1]) begin
            w_scale_dec = 2'd2;
        end else if (i_scale_sel[0]) begin
            w_scale_dec = 2'd1;
        end else begin
            w_scale_dec = 2'd0;
        end
    end

    // Raster counters; the replication factor only changes on entry to (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= H_START;
            r_v_cnt <= V_START;
            r_scale <= 2'd0;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
            if (w_frame_wrap) begin
                r_scale <= w_scale_dec;
            end
        end
    end

    // Stage 0: control decoded straight from the counters.
    always_comb begin
        w_h32 = 32'(r_h_cnt);
        w_v32 = 32'(r_v_cnt);
        case (r_scale)
            2'd1:    w_low_mask = 2'b01;
            2'd2:    w_low_mask = 2'b11;
            default: w_low_mask = 2'b00;
        endcase
        w_stage0        = '0;
        w_stage0.active = (w_h32 < H_DISPLAY) && (w_v32 < V_DISPLAY);
        w_stage0.req    = w_stage0.active && ((r_h_cnt[1:0] & w_low_mask) == 2'b00);
        w_stage0.hs     = (w_h32 >= H_SYNC_START) && (w_h32 < H_SYNC_END);
        w_stage0.vs     = (w_v32 >= V_SYNC_START) && (w_v32 < V_SYNC_END);
        w_stage0.first  = (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    assign o_pixel_req = w_stage0.req;
    assign o_src_x     = r_h_cnt >> r_scale;
    assign o_src_y     = r_v_cnt;

    // Delay line matching the control path to the fetch latency.
    generate
        if (PIX_LATENCY == 0) begin : g_lat0
            assign w_tail = w_stage0;
        end else begin : g_lat
            localparam int unsigned DW = PIX_LATENCY * SW;
            logic [DW-1:0] r_dly;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= DW'({r_dly, w_stage0});
                end
            end

            assign w_tail = stage_t'(r_dly[DW-1 -: SW]);
        end
    endgenerate

    // Pixel for this output slot: fresh on a request slot (black if missing),
    // otherwise the held value is replicated.
    always_comb begin
        w_pix_next = r_hold;
        if (w_tail.req) begin
            w_pix_next = i_rgb_valid ? i_rgb_in : 8'h00;
        end
    end

    // Output registers, loaded from the delay-line tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b0;
            r_rgb         <= 8'h00;
            r_hold        <= 8'h00;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_hsync       <= w_tail.hs ~^ HSYNC_POL;
            r_vsync       <= w_tail.vs ~^ VSYNC_POL;
            r_de          <= w_tail.active;
            r_hold        <= w_pix_next;
            r_rgb         <= w_tail.active ? w_pix_next : 8'h00;
            r_frame_start <= w_tail.first;
            // A miss on pixel (0,0) wins over the frame-start clear.
            if (w_tail.req && !i_rgb_valid) begin
                r_underflow <= 1'b1;
            end else if (w_tail.first) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_red         = r_rgb[7:5];
    assign o_green       = r_rgb[4:2];
    assign o_blue        = r_rgb[1:0];
    assign o_frame_start = r_frame_start;
    assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_vga_timing_scaler.sv
// Bench for vga_timing_scaler: two instances on a reduced raster, one with
// active-low syncs and latency 1, one with active-high syncs and latency 3.
// A position-level reference model queues the expected outputs of every
// raster position; each queue is popped when the instance's registered
// outputs for that position appear.

module tb_vga_timing_scaler;

    localparam int unsigned HD  = 16;
    localparam int unsigned HF  = 2;
    localparam int unsigned HS  = 3;
    localparam int unsigned HB  = 3;
    localparam int unsigned VD  = 6;
    localparam int unsigned VF  = 1;
    localparam int unsigned VS  = 2;
    localparam int unsigned VB  = 2;
    localparam int unsigned HT  = HD + HF + HS + HB;
    localparam int unsigned VT  = VD + VF + VS + VB;
    localparam int unsigned CW  = 8;
    localparam int unsigned LA  = 1;
    localparam int unsigned LB  = 3;
    localparam int unsigned PAW = 9 * (LA + 1);
    localparam int unsigned PBW = 9 * (LB + 1);

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       uf;
        logic [7:0] rgb;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [1:0]    scale_sel;
    logic [7:0]    rgb_a, rgb_b;
    logic          val_a, val_b;
    logic          req_a, req_b;
    logic [CW-1:0] sx_a, sy_a, sx_b, sy_b;
    logic          hs_a, vs_a, de_a, fs_a, uf_a;
    logic          hs_b, vs_b, de_b, fs_b, uf_b;
    logic [2:0]    red_a, green_a, red_b, green_b;
    logic [1:0]    blue_a, blue_b;

    int   errors = 0;
    int   checks = 0;
    int   h_m, v_m, s_m, tk;
    logic [7:0] hold_m;
    logic uf_m;
    bit   drop_en;
    int   first_fs_a, first_fs_b, last_fs_a, fs_period_a;
    logic [PAW-1:0] pa;
    logic [PBW-1:0] pb;
    exp_t qa[$];
    exp_t qb[$];

    vga_timing_scaler #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_LATENCY(LA), .CNT_W(CW)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_scale_sel(scale_sel),
        .i_rgb_in(rgb_a), .i_rgb_valid(val_a),
        .o_pixel_req(req_a), .o_src_x(sx_a), .o_src_y(sy_a),
        .o_hsync(hs_a), .o_vsync(vs_a), .o_de(de_a),
        .o_red(red_a), .o_green(green_a), .o_blue(blue_a),
        .o_frame_start(fs_a), .o_underflow(uf_a)
    );

    vga_timing_scaler #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_LATENCY(LB), .CNT_W(CW)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_scale_sel(scale_sel),
        .i_rgb_in(rgb_b), .i_rgb_valid(val_b),
        .o_pixel_req(req_b), .o_src_x(sx_b), .o_src_y(sy_b),
        .o_hsync(hs_b), .o_vsync(vs_b), .o_de(de_b),
        .o_red(red_b), .o_green(green_b), .o_blue(blue_b),
        .o_frame_start(fs_b), .o_underflow(uf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int scale_code(input logic [1:0] sel);
        if (sel[1]) return 2;
        if (sel[0]) return 1;
        return 0;
    endfunction

    // Expected outputs of the current model position, pushed to both queues.
    task automatic model_push(output bit req, output int sx);
        exp_t e;
        bit   act;
        bit   first;
        act   = (h_m < HD) && (v_m < VD);
        req   = act && ((h_m % (1 << s_m)) == 0);
        sx    = h_m >> s_m;
        first = (h_m == 0) && (v_m == 0);
        if (first) uf_m = 1'b0;
        if (req) begin
            if (drop_en && sx == 5 && v_m == 2) begin
                hold_m = 8'h00;
                uf_m   = 1'b1;
            end else begin
                hold_m = 8'(sx);
            end
        end
        e.de  = act;
        e.hs  = (h_m >= HD + HF) && (h_m < HD + HF + HS);
        e.vs  = (v_m >= VD + VF) && (v_m < VD + VF + VS);
        e.fs  = first;
        e.uf  = uf_m;
        e.rgb = act ? hold_m : 8'h00;
        qa.push_back(e);
        qb.push_back(e);
    endtask

    task automatic model_reset();
        bit dreq;
        int dsx;
        h_m = HD; v_m = VD; s_m = 0; hold_m = 8'h00; uf_m = 1'b0;
        qa.delete();
        qb.delete();
        repeat (LA) qa.push_back('0);
        repeat (LB) qb.push_back('0);
        model_push(dreq, dsx);
        pa = '0; pb = '0;
        rgb_a = 8'h00; val_a = 1'b0; rgb_b = 8'h00; val_b = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_de"},    32'(de_a), 32'(0));
        chk({tag, "_a_hsync"}, 32'(hs_a), 32'(1));
        chk({tag, "_a_vsync"}, 32'(vs_a), 32'(1));
        chk({tag, "_a_rgb"},   32'({red_a, green_a, blue_a}), 32'(0));
        chk({tag, "_a_fs"},    32'(fs_a), 32'(0));
        chk({tag, "_a_uf"},    32'(uf_a), 32'(0));
        chk({tag, "_a_req"},   32'(req_a), 32'(0));
        chk({tag, "_a_srcx"},  32'(sx_a), 32'(HD));
        chk({tag, "_a_srcy"},  32'(sy_a), 32'(VD));
        chk({tag, "_b_hsync"}, 32'(hs_b), 32'(0));
        chk({tag, "_b_vsync"}, 32'(vs_b), 32'(0));
        chk({tag, "_b_de"},    32'(de_b), 32'(0));
        chk({tag, "_b_rgb"},   32'({red_b, green_b, blue_b}), 32'(0));
    endtask

    // One pixel clock: advance model, compare, then drive the fetch returns.
    task automatic tick();
        exp_t e;
        bit   mreq;
        int   msx;
        @(posedge clk);
        #1;
        tk++;
        if (h_m == HT - 1) begin
            h_m = 0;
            v_m = (v_m == VT - 1) ? 0 : v_m + 1;
        end else begin
            h_m++;
        end
        if (h_m == 0 && v_m == 0) s_m = scale_code(scale_sel);

        if (qa.size() == 0) chk("a_queue_empty", 32'(qa.size()), 32'(1));
        else begin
            e = qa.pop_front();
            chk("a_de",    32'(de_a), 32'(e.de));
            chk("a_hsync", 32'(hs_a), 32'(!e.hs));
            chk("a_vsync", 32'(vs_a), 32'(!e.vs));
            chk("a_rgb",   32'({red_a, green_a, blue_a}), 32'(e.rgb));
            chk("a_fs",    32'(fs_a), 32'(e.fs));
            chk("a_uf",    32'(uf_a), 32'(e.uf));
        end
        if (qb.size() == 0) chk("b_queue_empty", 32'(qb.size()), 32'(1));
        else begin
            e = qb.pop_front();
            chk("b_de",    32'(de_b), 32'(e.de));
            chk("b_hsync", 32'(hs_b), 32'(e.hs));
            chk("b_vsync", 32'(vs_b), 32'(e.vs));
            chk("b_rgb",   32'({red_b, green_b, blue_b}), 32'(e.rgb));
            chk("b_fs",    32'(fs_b), 32'(e.fs));
            chk("b_uf",    32'(uf_b), 32'(e.uf));
        end

        model_push(mreq, msx);
        chk("a_req",  32'(req_a), 32'(mreq));
        chk("a_srcx", 32'(sx_a), 32'(msx));
        chk("a_srcy", 32'(sy_a), 32'(v_m));
        chk("b_req",  32'(req_b), 32'(mreq));
        chk("b_srcx", 32'(sx_b), 32'(msx));

        if (fs_a) begin
            if (first_fs_a < 0) first_fs_a = tk;
            if (last_fs_a >= 0) fs_period_a = tk - last_fs_a;
            last_fs_a = tk;
        end
        if (fs_b && first_fs_b < 0) first_fs_b = tk;

        // Upstream fetch: request data returns LA/LB cycles later; idle slots carry noise.
        if (req_a) pa = PAW'({pa, !(drop_en && sx_a == 5 && sy_a == 2), sx_a});
        else       pa = PAW'({pa, 9'($urandom)});
        if (req_b) pb = PBW'({pb, !(drop_en && sx_b == 5 && sy_b == 2), sx_b});
        else       pb = PBW'({pb, 9'($urandom)});
        rgb_a = pa[PAW-2 -: 8]; val_a = pa[PAW-1];
        rgb_b = pb[PBW-2 -: 8]; val_b = pb[PBW-1];
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(h_m == h && v_m == v) && n < int'(HT * VT + 2)) begin
            tick();
            n++;
        end
        chk("wait_pos", 32'(h_m == h && v_m == v), 32'(1));
    endtask

    // Counts requests, DE and asserted hsync over one full line period.
    task automatic count_line(input string tag, input int exp_req);
        int n_req, n_de, n_hs;
        wait_pos(0, 1);
        n_req = req_a ? 1 : 0;
        n_de  = de_a ? 1 : 0;
        n_hs  = hs_a ? 0 : 1;
        repeat (HT - 1) begin
            tick();
            n_req += req_a ? 1 : 0;
            n_de  += de_a ? 1 : 0;
            n_hs  += hs_a ? 0 : 1;
        end
        chk({tag, "_reqs"},  32'(n_req), 32'(exp_req));
        chk({tag, "_de"},    32'(n_de), 32'(HD));
        chk({tag, "_hsync"}, 32'(n_hs), 32'(HS));
    endtask

    initial begin
        rst_n = 1'b0; scale_sel = 2'b00; drop_en = 1'b0;
        tk = 0; first_fs_a = -1; first_fs_b = -1; last_fs_a = -1; fs_period_a = -1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // First frame start from reset release.
        run(120);
        chk("first_fs_a", 32'(first_fs_a), 32'((HT - HD) + HT * (VT - VD - 1) + LA + 1));
        chk("first_fs_b", 32'(first_fs_b), 32'((HT - HD) + HT * (VT - VD - 1) + LB + 1));

        // Missing pixel at (5,2) in 1x: black pixel, sticky underflow.
        drop_en = 1'b1;
        run(60);
        drop_en = 1'b0;
        chk("uf_set_a", 32'(uf_a), 32'(1));
        chk("uf_set_b", 32'(uf_b), 32'(1));
        run(200);
        chk("uf_clr_a", 32'(uf_a), 32'(0));
        chk("uf_clr_b", 32'(uf_b), 32'(0));
        chk("frame_period", 32'(fs_period_a), 32'(HT * VT));

        // 1x line, then 2x from the next frame.
        scale_sel = 2'b01;
        count_line("line_1x", HD);
        count_line("line_2x", HD / 2);

        // Mid-frame switch to 4x is deferred to the next frame.
        wait_pos(5, 0);
        scale_sel = 2'b10;
        count_line("line_2x_hold", HD / 2);
        count_line("line_4x", HD / 4);
        scale_sel = 2'b11;
        count_line("line_4x_b", HD / 4);

        // Reset in the middle of a frame.
        wait_pos(3, 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tk = 0; first_fs_a = -1; first_fs_b = -1; last_fs_a = -1;
        run(120);
        chk("midrst_fs_a", 32'(first_fs_a), 32'((HT - HD) + HT * (VT - VD - 1) + LA + 1));
        chk("midrst_fs_b", 32'(first_fs_b), 32'((HT - HD) + HT * (VT - VD - 1) + LB + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_scaler.md
Name: vga_timing_scaler

Overview:
- Parametrised successor of the 640x480 VGA display block.
- Generates programmable H/V timing with configurable sync polarity.
- Requests source pixels at 1x/2x/4x horizontal replication and exports source coordinates for upstream addressing.
- Tolerates PIX_LATENCY cycles of fetch latency, aligns sync/DE/RGB to that latency, and flags pixel underflow.
- Sits between the instruction decoder / pixel fetch path and the VGA pins.

Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, active lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BACK, 33, vertical back porch
- HSYNC_POL, 0, active level of hsync (0 = active low)
- VSYNC_POL, 0, active level of vsync
- PIX_LATENCY, 1, cycles from pixel_req to rgb_in valid (0..3)
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock (25 MHz at defaults)
- rst_n  in  1  asynchronous active-low reset
- scale_sel  in  2  00 = 1x, 01 = 2x, 1x = 4x horizontal replication; sampled at frame boundary
- rgb_in  in  8  RRRGGGBB pixel, valid PIX_LATENCY cycles after pixel_req
- rgb_valid  in  1  qualifies rgb_in at its sample point
- pixel_req  out  1  combinational; request next source pixel
- src_x  out  CNT_W  h_cnt >> scale shift; meaningful while pixel_req is high
- src_y  out  CNT_W  v_cnt (no vertical scaling)
- hsync  out  1  registered, polarity per HSYNC_POL
- vsync  out  1  registered, polarity per VSYNC_POL
- de  out  1  registered display enable
- red  out  3  registered
- green  out  3  registered
- blue  out  2  registered
- frame_start  out  1  registered one-cycle pulse aligned with first active pixel of frame
- underflow  out  1  sticky pixel-underflow flag

Behaviour:
- Reset (async assert; release sampled on clk):
  - h_cnt = H_DISPLAY, v_cnt = V_DISPLAY, so the block starts in blanking.
  - Active scale = 1x.
  - hsync/vsync at inactive level; de = 0; rgb = 0; frame_start = 0; underflow = 0.
  - All delay-pipeline stages cleared to the inactive/zero state.
- Counters: h_cnt increments every cycle and wraps at H_TOTAL-1 to 0. On that wrap, v_cnt increments and wraps at V_TOTAL-1 to 0.
- Scale shift: S = 0/1/2 for 1x/2x/4x. The active scale latches scale_sel only in the cycle the counters move to (0,0); mid-frame changes are ignored.
- Stage 0 (combinational from counters):
  - active = h_cnt < H_DISPLAY && v_cnt < V_DISPLAY.
  - pixel_req = active && low S bits of h_cnt == 0.
  - hs_raw = H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC.
  - vs_raw uses the same rule with the V parameters.
- Alignment:
  - active, hs_raw, vs_raw, pixel_req and the (0,0) indicator travel through a PIX_LATENCY-deep delay line.
  - Output registers load from the delay-line tail, so the outputs for counter position (h,v) at cycle t appear at t+PIX_LATENCY+1.
  - With PIX_LATENCY = 0 this gives exactly one cycle latency.
- Pixel capture:
  - When the delayed pixel_req is high: if rgb_valid = 1, hold register <= rgb_in; otherwise hold register <= 0 and underflow <= 1.
  - Delayed active with delayed pixel_req low: hold register is unchanged (replication).
  - Output RGB = captured/held value when delayed active is high, else 0.
- Sync outputs: hsync = hs_raw XNOR HSYNC_POL, i.e. the active level equals HSYNC_POL. vsync follows the same rule with VSYNC_POL.
- de = delayed active.
- frame_start = 1 for exactly one cycle, coincident with the output of pixel (0,0).
- underflow:
  - Sticky across lines.
  - Cleared in the same cycle frame_start is emitted.
  - If an underflow occurs on pixel (0,0), set has priority over clear (flag ends at 1).
- rgb_valid outside a delayed pixel_req slot is ignored.
- Width: H_DISPLAY not divisible by 4 in 4x mode means the last partial group repeats fewer times; no error.
- Reset mid-frame: immediate return to the reset state; the next frame_start occurs after the counters traverse to (0,0).

Test Plan:
- Defaults, 1x, PIX_LATENCY=1, rgb_valid=1, rgb_in=8'hE3 held -> de high for 640 cycles per line; red=7, green=0, blue=3; hsync low for 96 cycles starting 16 after de falls; line period 800; frame period 420000 cycles.
- Reset release -> first frame_start exactly (800-640)+800*(525-480-1)+PIX_LATENCY+1 cycles later; hsync/vsync high and rgb 0 before that.
- scale_sel=01, rgb_in = src_x[7:0] -> pixel_req every 2nd active cycle; output pixels 0,0,1,1,2,2..., 319,319 per line; 320 requests per line.
- scale_sel=1x changed mid-frame -> no effect until next frame_start; then 160 requests per line, each value repeated 4 times.
- rgb_valid=0 for one request at src_x=5 (1x) -> output pixel 5 black; underflow=1 until next frame_start, then 0.
- HSYNC_POL=1, VSYNC_POL=1, PIX_LATENCY=3 -> sync pulses active high with same widths; all outputs shifted 3 cycles later than the PIX_LATENCY=0 run.
